// File: rtl/bias_seq_if.sv
// bias_seq_if: HLS-style FIFO write port carrying bias words
// from the sequencer (master) to the layer's bias FIFO (slave).
interface bias_seq_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] output_V_din;
  logic                  output_V_full_n;
  logic                  output_V_write;

  modport master (
    output output_V_din,
    output output_V_write,
    input  output_V_full_n
  );

  modport slave (
    input  output_V_din,
    input  output_V_write,
    output output_V_full_n
  );
endinterface

// File: rtl/bias_seq.sv
// bias_seq: sweeps a synchronous bias ROM `frames` times and streams
// each word into a full_n-backpressured FIFO write port.
module bias_seq #(
  parameter  int MEM_SIZE   = 9,
  parameter  int DATA_WIDTH = 16,
  parameter  int FRAME_W    = 16,
  localparam int AW         = $clog2(MEM_SIZE)
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ap_start,
  input  logic [FRAME_W-1:0]    frames,
  output logic                  ap_idle,
  output logic                  ap_done,
  output logic [AW-1:0]         rom_address,
  output logic                  rom_ce,
  input  logic [DATA_WIDTH-1:0] rom_q,
  bias_seq_if.master            out_if
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [AW-1:0] LAST_A = AW'(MEM_SIZE - 1);

  logic [1:0]            state_q, state_d;
  logic [FRAME_W-1:0]    frames_q, frames_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [FRAME_W-1:0]    ifrm_q, ifrm_d;
  logic [AW-1:0]         acc_q, acc_d;
  logic [FRAME_W-1:0]    afrm_q, afrm_d;

  logic [DATA_WIDTH-1:0] buf_q [2];
  logic                  rd_ptr_q, wr_ptr_q;
  logic [1:0]            cnt_q;
  logic                  infl_q;

  logic                  run;
  logic                  rd_left;
  logic                  pop;
  logic                  push;
  logic [2:0]            level;
  logic                  ce;
  logic                  acc_last;

  assign run     = (state_q == S_RUN);
  assign rd_left = (ifrm_q != frames_q);
  assign pop     = (cnt_q != 2'd0) & out_if.output_V_full_n;
  assign push    = infl_q;

  // Slots already claimed once this cycle's pop leaves.
  assign level = {1'b0, cnt_q}
               + {2'b00, infl_q}
               - {2'b00, pop};

  assign ce = run & rd_left & (level < 3'd2);

  assign acc_last = (acc_q == LAST_A)
                  & (afrm_q == frames_q - FRAME_W'(1));

  assign ap_idle     = (state_q == S_IDLE);
  assign ap_done     = (state_q == S_DONE);
  assign rom_ce      = ce;
  assign rom_address = addr_q;

  assign out_if.output_V_din   = buf_q[rd_ptr_q];
  assign out_if.output_V_write = pop;

  always_comb begin
    state_d  = state_q;
    frames_d = frames_q;
    addr_d   = addr_q;
    ifrm_d   = ifrm_q;
    acc_d    = acc_q;
    afrm_d   = afrm_q;
    unique case (1'b1)
      state_q == S_IDLE: begin
        if (ap_start) begin
          frames_d = frames;
          addr_d   = '0;
          ifrm_d   = '0;
          acc_d    = '0;
          afrm_d   = '0;
          state_d  = (frames != '0) ? S_RUN : S_DONE;
        end
      end
      state_q == S_RUN: begin
        if (ce) begin
          if (addr_q == LAST_A) begin
            addr_d = '0;
            ifrm_d = ifrm_q + FRAME_W'(1);
          end else begin
            addr_d = addr_q + AW'(1);
          end
        end
        if (pop) begin
          if (acc_q == LAST_A) begin
            acc_d  = '0;
            afrm_d = afrm_q + FRAME_W'(1);
          end else begin
            acc_d = acc_q + AW'(1);
          end
          if (acc_last) state_d = S_DONE;
        end
      end
      state_q == S_DONE: state_d = S_IDLE;
      default:           state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q  <= S_IDLE;
      frames_q <= '0;
      addr_q   <= '0;
      ifrm_q   <= '0;
      acc_q    <= '0;
      afrm_q   <= '0;
    end else begin
      state_q  <= state_d;
      frames_q <= frames_d;
      addr_q   <= addr_d;
      ifrm_q   <= ifrm_d;
      acc_q    <= acc_d;
      afrm_q   <= afrm_d;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      infl_q   <= 1'b0;
    end else begin
      infl_q <= ce;
      if (push) buf_q[wr_ptr_q] <= rom_q;
      wr_ptr_q <= wr_ptr_q ^ push;
      rd_ptr_q <= rd_ptr_q ^ pop;
      cnt_q    <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_bias_seq.sv
// tb_bias_seq: scoreboard bench for bias_seq with a cycle-level
// reference of write timing derived from the full_n pattern.
module tb_bias_seq;

  localparam int MS = 4;
  localparam int DW = 8;
  localparam int FW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [FW-1:0] frames = '0;
  logic          idle, done;
  logic [1:0]    addr;
  logic          ce;
  logic [DW-1:0] rom_q = '0;

  bias_seq_if #(.DATA_WIDTH(DW)) oif ();

  bias_seq #(
    .MEM_SIZE  (MS),
    .DATA_WIDTH(DW),
    .FRAME_W   (FW)
  ) dut (
    .ap_clk     (clk),
    .ap_rst_n   (rst_n),
    .ap_start   (start),
    .frames     (frames),
    .ap_idle    (idle),
    .ap_done    (done),
    .rom_address(addr),
    .rom_ce     (ce),
    .rom_q      (rom_q),
    .out_if     (oif.master)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] rom [MS];
  always @(posedge clk) if (ce) rom_q <= rom[addr];

  int pos_cnt = 0;
  always @(posedge clk) pos_cnt <= pos_cnt + 1;

  int n_chk = 0;
  int n_fail = 0;

  int mode = 0;
  int k_start = 0;
  bit rbits [64];

  logic [DW-1:0] exp_q [$];
  int wc_q [$];
  int dc_q [$];
  int ce_tot = 0;
  int wr_tot = 0;
  int viol = 0;

  // full_n seen by the DUT during cycle c (cycle k+1 follows edge k)
  function automatic bit fn(input int c);
    if (mode == 1) return !(c >= k_start + 4 && c <= k_start + 8);
    if (mode == 2) begin
      if (c < k_start + 3) return 1'b1;
      return ((c - k_start - 3) % 2) == 0;
    end
    if (mode == 3) begin
      if (c < k_start) return 1'b1;
      return rbits[(c - k_start) % 64];
    end
    return 1'b1;
  endfunction

  initial begin
    oif.output_V_full_n = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      oif.output_V_full_n = fn(pos_cnt + 1);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  initial begin : monitor
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (ce) ce_tot++;
        if (oif.output_V_write) begin
          wr_tot++;
          wc_q.push_back(pos_cnt + 1);
          n_chk++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL data: unexpected write din=%0d, required none",
                     oif.output_V_din);
          end else begin
            e = exp_q.pop_front();
            if (oif.output_V_din !== e) begin
              n_fail++;
              $display("FAIL data: got %0d, required %0d",
                       oif.output_V_din, e);
            end
          end
        end
        if (ce_tot - wr_tot > 2) viol++;
        if (done) dc_q.push_back(pos_cnt + 1);
      end
    end
  end

  task automatic chk_rst_outs(input string tag);
    chk({tag, " idle"}, 32'(idle), 1);
    chk({tag, " done"}, 32'(done), 0);
    chk({tag, " rom_ce"}, 32'(ce), 0);
    chk({tag, " rom_address"}, 32'(addr), 0);
    chk({tag, " write"}, 32'(oif.output_V_write), 0);
    chk({tag, " din"}, 32'(oif.output_V_din), 0);
  endtask

  task automatic do_run(input int fr, input int md, input int hold);
    int n, k, t, c, got, d, runs, lim, cyc;
    int ewc [$];
    int edc [$];
    @(negedge clk);
    #1;
    wc_q.delete();
    dc_q.delete();
    ce_tot = 0;
    wr_tot = 0;
    viol = 0;
    if (md == 3)
      for (int i = 0; i < 64; i++) rbits[i] = ($urandom_range(2, 0) != 0);
    mode = md;
    k = pos_cnt + 1;
    k_start = k;
    frames = FW'(fr);
    start = 1'b1;
    n = fr * MS;
    t = k;
    lim = k + hold - 1;
    runs = 0;
    forever begin
      for (int f = 0; f < fr; f++)
        for (int a = 0; a < MS; a++) exp_q.push_back(rom[a]);
      if (n == 0) begin
        d = t + 1;
      end else begin
        c = t + 3;
        got = 0;
        while (got < n) begin
          if (fn(c)) begin
            ewc.push_back(c);
            got++;
          end
          c++;
        end
        d = c;
      end
      edc.push_back(d);
      runs++;
      t = d + 1;
      if (t > lim) break;
    end
    repeat (hold) @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0;
    while (dc_q.size() < runs && cyc < 600) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    chk("done count", 32'(dc_q.size()), 32'(runs));
    @(negedge clk);
    #1;
    chk("idle after done", 32'(idle), 1);
    chk("rom_ce after done", 32'(ce), 0);
    chk("write count", 32'(wc_q.size()), 32'(ewc.size()));
    for (int i = 0; i < ewc.size() && i < wc_q.size(); i++)
      chk("write cycle", 32'(wc_q[i] - k), 32'(ewc[i] - k));
    for (int i = 0; i < edc.size() && i < dc_q.size(); i++)
      chk("done cycle", 32'(dc_q[i] - k), 32'(edc[i] - k));
    chk("rom_ce count", 32'(ce_tot), 32'(n * runs));
    chk("buffer bound", 32'(viol), 0);
    chk("scoreboard drained", 32'(exp_q.size()), 0);
    exp_q.delete();
  endtask

  task automatic reset_mid_run();
    int cyc, snap;
    @(negedge clk);
    #1;
    wc_q.delete();
    dc_q.delete();
    ce_tot = 0;
    wr_tot = 0;
    viol = 0;
    mode = 0;
    k_start = pos_cnt + 1;
    for (int f = 0; f < 2; f++)
      for (int a = 0; a < MS; a++) exp_q.push_back(rom[a]);
    frames = FW'(2);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0;
    while (wr_tot < 3 && cyc < 100) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    chk("writes before reset", 32'(wr_tot), 3);
    rst_n = 1'b0;
    #1;
    chk_rst_outs("mid-run reset");
    exp_q.delete();
    repeat (2) @(negedge clk);
    #1;
    chk_rst_outs("held reset");
    rst_n = 1'b1;
    snap = wr_tot;
    repeat (10) @(negedge clk);
    #1;
    chk("no writes after reset", 32'(wr_tot), 32'(snap));
    chk("no done after reset", 32'(dc_q.size()), 0);
  endtask

  initial begin
    for (int a = 0; a < MS; a++) rom[a] = DW'(a + 1);
    repeat (3) @(negedge clk);
    #1;
    chk_rst_outs("in reset");
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk_rst_outs("after release");

    do_run(2, 0, 1);
    do_run(2, 1, 1);
    do_run(2, 2, 1);
    do_run(0, 0, 1);
    reset_mid_run();
    do_run(1, 0, 1);
    do_run(1, 0, 20);

    repeat (4) begin
      for (int a = 0; a < MS; a++) rom[a] = DW'($urandom);
      do_run(int'($urandom_range(3, 1)), 3, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
